// File: rtl/pkt_ingress_writer_if.sv
// Beat-stream input and packet-buffer FIFO write port seen by the ingress writer.
interface pkt_ingress_writer_if #(
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned DATA_W     = 18
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_W-1:0]     in_data;
  logic                  in_sop;
  logic                  in_eop;
  logic                  in_drop;
  logic [DATA_W+1:0]     fifo_wdata;
  logic                  fifo_wen;
  logic                  fifo_full;
  logic [ADDR_WIDTH:0]   fifo_wptr;
  logic                  fifo_wrst;
  logic [ADDR_WIDTH:0]   fifo_rst_wptr;

  // Upstream source and FIFO side
  modport master (
    output in_valid, in_data, in_sop, in_eop, in_drop, fifo_full, fifo_wptr,
    input  in_ready, fifo_wdata, fifo_wen, fifo_wrst, fifo_rst_wptr
  );

  // Ingress writer side
  modport slave (
    input  in_valid, in_data, in_sop, in_eop, in_drop, fifo_full, fifo_wptr,
    output in_ready, fifo_wdata, fifo_wen, fifo_wrst, fifo_rst_wptr
  );
endinterface

// File: rtl/pkt_ingress_writer.sv
// Writes packet beats into the packet buffer, commits accepted packets and
// rewinds the FIFO write pointer to the packet start on rejected ones.
module pkt_ingress_writer #(
  parameter int unsigned ADDR_WIDTH  = 11,
  parameter int unsigned DATA_W      = 18,
  parameter int unsigned MAX_PKT_LEN = 1518,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  pkt_ingress_writer_if.slave     bus,
  output logic [ADDR_WIDTH:0]     commit_wptr,
  output logic [CNT_W-1:0]        pkt_ok_cnt,
  output logic [CNT_W-1:0]        pkt_drop_cnt,
  output logic [CNT_W-1:0]        orphan_cnt
);
  localparam int unsigned PTR_W = ADDR_WIDTH + 1;
  localparam int unsigned LEN_W = $clog2(MAX_PKT_LEN + 1);

  if (MAX_PKT_LEN > (2**ADDR_WIDTH) - 1) begin : g_bad_len
    $error("MAX_PKT_LEN must not exceed 2**ADDR_WIDTH-1");
  end

  typedef enum logic [1:0] {IDLE, PKT, DISCARD, REWIND} state_t;

  state_t             state, state_nxt;
  logic [PTR_W-1:0]   sop_wptr, sop_wptr_nxt;
  logic [PTR_W-1:0]   commit_nxt;
  logic [LEN_W-1:0]   pkt_len, pkt_len_nxt;
  logic               ready_c, wen_c;
  logic               ok_inc_c, drop_inc_c, orphan_inc_c;
  logic               wrst_q;
  logic [PTR_W-1:0]   rst_wptr_q;

  // Next-state, write strobe and bookkeeping
  always_comb begin
    state_nxt    = state;
    sop_wptr_nxt = sop_wptr;
    commit_nxt   = commit_wptr;
    pkt_len_nxt  = pkt_len;
    ready_c      = 1'b0;
    wen_c        = 1'b0;
    ok_inc_c     = 1'b0;
    drop_inc_c   = 1'b0;
    orphan_inc_c = 1'b0;
    case (state)
      IDLE: begin
        ready_c = !bus.fifo_full;
        if (bus.in_valid && ready_c) begin
          if (!bus.in_sop) begin
            orphan_inc_c = 1'b1;
          end else if (!bus.in_eop) begin
            wen_c        = 1'b1;
            sop_wptr_nxt = bus.fifo_wptr;
            pkt_len_nxt  = LEN_W'(1);
            state_nxt    = PKT;
          end else if (!bus.in_drop) begin
            wen_c      = 1'b1;
            commit_nxt = PTR_W'(bus.fifo_wptr + 1'b1);
            ok_inc_c   = 1'b1;
          end else begin
            drop_inc_c = 1'b1;
          end
        end
      end
      PKT: begin
        ready_c = !bus.fifo_full && !bus.in_sop;
        // A new sop inside a packet is a protocol error: hold it and roll back
        if (bus.in_valid && bus.in_sop) begin
          drop_inc_c = 1'b1;
          state_nxt  = REWIND;
        end else if (bus.in_valid && ready_c) begin
          if (!bus.in_eop) begin
            wen_c       = 1'b1;
            pkt_len_nxt = LEN_W'(pkt_len + 1'b1);
            if (pkt_len_nxt == LEN_W'(MAX_PKT_LEN)) begin
              drop_inc_c = 1'b1;
              state_nxt  = DISCARD;
            end
          end else if (!bus.in_drop) begin
            wen_c      = 1'b1;
            commit_nxt = PTR_W'(bus.fifo_wptr + 1'b1);
            ok_inc_c   = 1'b1;
            state_nxt  = IDLE;
          end else begin
            drop_inc_c = 1'b1;
            state_nxt  = REWIND;
          end
        end
      end
      DISCARD: begin
        ready_c = 1'b1;
        if (bus.in_valid && bus.in_eop) state_nxt = REWIND;
      end
      REWIND: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.in_ready      = ready_c;
  assign bus.fifo_wen      = wen_c;
  assign bus.fifo_wdata    = {bus.in_sop, bus.in_eop, bus.in_data};
  assign bus.fifo_wrst     = wrst_q;
  assign bus.fifo_rst_wptr = rst_wptr_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      sop_wptr     <= '0;
      pkt_len      <= '0;
      commit_wptr  <= '0;
      pkt_ok_cnt   <= '0;
      pkt_drop_cnt <= '0;
      orphan_cnt   <= '0;
      wrst_q       <= 1'b0;
      rst_wptr_q   <= '0;
    end else begin
      state       <= state_nxt;
      sop_wptr    <= sop_wptr_nxt;
      pkt_len     <= pkt_len_nxt;
      commit_wptr <= commit_nxt;
      if (ok_inc_c)     pkt_ok_cnt   <= CNT_W'(pkt_ok_cnt + 1'b1);
      if (drop_inc_c)   pkt_drop_cnt <= CNT_W'(pkt_drop_cnt + 1'b1);
      if (orphan_inc_c) orphan_cnt   <= CNT_W'(orphan_cnt + 1'b1);
      // Rewind strobe is high for exactly the REWIND cycle
      wrst_q     <= (state_nxt == REWIND);
      rst_wptr_q <= sop_wptr_nxt;
    end
  end
endmodule

// File: tb/tb_pkt_ingress_writer.sv
// Directed bench for pkt_ingress_writer with a pointer-only FIFO model.
module tb_pkt_ingress_writer;
  localparam int unsigned AW = 4;
  localparam int unsigned DW = 18;

  logic clk = 1'b0;
  logic reset;
  logic [AW:0] commit_wptr;
  logic [15:0] pkt_ok_cnt, pkt_drop_cnt, orphan_cnt;
  int checks = 0;
  int failures = 0;
  int wr_cnt = 0;
  int wr0;

  always #5 clk = ~clk;

  pkt_ingress_writer_if #(.ADDR_WIDTH(AW), .DATA_W(DW)) bus ();

  pkt_ingress_writer #(.ADDR_WIDTH(AW), .DATA_W(DW), .MAX_PKT_LEN(8), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .bus(bus), .commit_wptr(commit_wptr),
    .pkt_ok_cnt(pkt_ok_cnt), .pkt_drop_cnt(pkt_drop_cnt), .orphan_cnt(orphan_cnt)
  );

  // FIFO write pointer: reset, reload on wrst, advance on wen
  always @(posedge clk) begin
    if (!reset) bus.fifo_wptr <= '0;
    else if (bus.fifo_wrst) bus.fifo_wptr <= bus.fifo_rst_wptr;
    else if (bus.fifo_wen) begin
      bus.fifo_wptr <= bus.fifo_wptr + 1'b1;
      wr_cnt <= wr_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      checks++;
      assert (!(bus.fifo_wen && bus.fifo_wrst)) else begin
        failures++;
        $error("FAIL wen_wrst_overlap observed=1 expected=0");
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic v, input logic s, input logic e, input logic d,
                        input logic [DW-1:0] data);
    bus.in_valid = v; bus.in_sop = s; bus.in_eop = e; bus.in_drop = d; bus.in_data = data;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    logic [AW:0] exp_ptr;
    reset = 1'b0;
    bus.fifo_full = 1'b0;
    set_in(0, 0, 0, 0, '0);
    repeat (2) tick();
    check("rst_commit", 32'(commit_wptr), 0);
    check("rst_ok", 32'(pkt_ok_cnt), 0);
    check("rst_drop", 32'(pkt_drop_cnt), 0);
    check("rst_orphan", 32'(orphan_cnt), 0);
    check("rst_wrst", 32'(bus.fifo_wrst), 0);
    check("rst_rst_wptr", 32'(bus.fifo_rst_wptr), 0);
    check("rst_wen", 32'(bus.fifo_wen), 0);
    reset = 1'b1;
    tick();

    // Committed 4-beat packet
    for (int i = 1; i <= 4; i++) begin
      set_in(1, i == 1, i == 4, 0, DW'(i));
      #1;
      check("a_wen", 32'(bus.fifo_wen), 1);
      check("a_wdata", 32'(bus.fifo_wdata), 32'({i == 1, i == 4, DW'(i)}));
      tick();
    end
    set_in(0, 0, 0, 0, '0);
    check("a_commit", 32'(commit_wptr), 4);
    check("a_ok", 32'(pkt_ok_cnt), 1);
    check("a_wptr", 32'(bus.fifo_wptr), 4);

    // 3-beat packet with drop verdict
    for (int i = 1; i <= 3; i++) begin
      set_in(1, i == 1, i == 3, i == 3, DW'(4 + i));
      #1;
      check("b_wen", 32'(bus.fifo_wen), 32'(i != 3));
      check("b_ready", 32'(bus.in_ready), 1);
      tick();
    end
    set_in(0, 0, 0, 0, '0);
    #1;
    check("b_wrst", 32'(bus.fifo_wrst), 1);
    check("b_rst_wptr", 32'(bus.fifo_rst_wptr), 4);
    check("b_ready_rewind", 32'(bus.in_ready), 0);
    check("b_drop", 32'(pkt_drop_cnt), 1);
    tick();
    check("b_wrst_off", 32'(bus.fifo_wrst), 0);
    check("b_wptr", 32'(bus.fifo_wptr), 4);
    check("b_commit", 32'(commit_wptr), 4);

    // 12-beat packet truncated at 8 beats
    wr0 = wr_cnt;
    for (int i = 1; i <= 12; i++) begin
      set_in(1, i == 1, i == 12, 0, DW'(16 + i));
      #1;
      check("t_wen", 32'(bus.fifo_wen), 32'(i <= 8));
      check("t_ready", 32'(bus.in_ready), 1);
      tick();
    end
    set_in(0, 0, 0, 0, '0);
    check("t_drop", 32'(pkt_drop_cnt), 2);
    check("t_writes", 32'(wr_cnt - wr0), 8);
    check("t_wrst", 32'(bus.fifo_wrst), 1);
    check("t_rst_wptr", 32'(bus.fifo_rst_wptr), 4);
    tick();
    check("t_wptr", 32'(bus.fifo_wptr), 4);
    check("t_commit", 32'(commit_wptr), 4);

    // sop arriving inside a packet
    set_in(1, 1, 0, 0, DW'('hA)); tick();
    set_in(1, 0, 0, 0, DW'('hB)); tick();
    set_in(1, 1, 1, 0, DW'('hC));
    #1;
    check("s_ready_held", 32'(bus.in_ready), 0);
    check("s_wen_held", 32'(bus.fifo_wen), 0);
    tick();
    check("s_drop", 32'(pkt_drop_cnt), 3);
    check("s_wrst", 32'(bus.fifo_wrst), 1);
    check("s_rst_wptr", 32'(bus.fifo_rst_wptr), 4);
    check("s_ready_rewind", 32'(bus.in_ready), 0);
    check("s_wen_rewind", 32'(bus.fifo_wen), 0);
    tick();
    check("s_wptr", 32'(bus.fifo_wptr), 4);
    check("s_ready_new", 32'(bus.in_ready), 1);
    check("s_wen_new", 32'(bus.fifo_wen), 1);
    check("s_wdata_new", 32'(bus.fifo_wdata), 32'({1'b1, 1'b1, DW'('hC)}));
    tick();
    set_in(0, 0, 0, 0, '0);
    check("s_commit", 32'(commit_wptr), 5);
    check("s_ok", 32'(pkt_ok_cnt), 2);
    check("s_wptr_after", 32'(bus.fifo_wptr), 5);

    // Orphan beats in IDLE
    for (int i = 1; i <= 3; i++) begin
      set_in(1, 0, i == 3, 0, DW'(32 + i));
      #1;
      check("o_wen", 32'(bus.fifo_wen), 0);
      check("o_ready", 32'(bus.in_ready), 1);
      tick();
    end
    set_in(0, 0, 0, 0, '0);
    check("o_orphan", 32'(orphan_cnt), 3);
    check("o_wptr", 32'(bus.fifo_wptr), 5);

    // Single-beat packet with drop verdict: no write, no rewind
    set_in(1, 1, 1, 1, DW'('h33));
    #1;
    check("d1_wen", 32'(bus.fifo_wen), 0);
    tick();
    set_in(0, 0, 0, 0, '0);
    check("d1_drop", 32'(pkt_drop_cnt), 4);
    check("d1_wrst", 32'(bus.fifo_wrst), 0);
    check("d1_commit", 32'(commit_wptr), 5);

    // fifo_full held 5 cycles mid-packet
    set_in(1, 1, 0, 0, DW'('hD)); tick();
    bus.fifo_full = 1'b1;
    set_in(1, 0, 0, 0, DW'('hE));
    repeat (5) begin
      #1;
      check("f_ready", 32'(bus.in_ready), 0);
      check("f_wen", 32'(bus.fifo_wen), 0);
      tick();
    end
    bus.fifo_full = 1'b0;
    #1;
    check("f_ready_resume", 32'(bus.in_ready), 1);
    check("f_wen_resume", 32'(bus.fifo_wen), 1);
    tick();
    set_in(1, 0, 1, 0, DW'('hF)); tick();
    set_in(0, 0, 0, 0, '0);
    check("f_commit", 32'(commit_wptr), 8);
    check("f_ok", 32'(pkt_ok_cnt), 3);
    check("f_drop", 32'(pkt_drop_cnt), 4);
    check("f_wptr", 32'(bus.fifo_wptr), 8);

    // Three 8-beat committed packets; the last wraps commit_wptr 31 -> 0
    for (int p = 0; p < 3; p++) begin
      for (int i = 1; i <= 8; i++) begin
        set_in(1, i == 1, i == 8, 0, DW'(64 + 8 * p + i));
        tick();
      end
      set_in(0, 0, 0, 0, '0);
      exp_ptr = (AW + 1)'(16 + 8 * p);
      check("w_commit", 32'(commit_wptr), 32'(exp_ptr));
    end
    check("w_ok", 32'(pkt_ok_cnt), 6);
    check("w_wptr", 32'(bus.fifo_wptr), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pkt_ingress_writer.md
Name: pkt_ingress_writer

Overview:
- Ingress stage directly upstream of the packet buffer FIFO; the FIFO is built with resettable pointers.
- Accepts a beat stream with sop/eop markers and a per-packet verdict on the eop beat, and writes beats into the FIFO.
- Commits accepted packets by publishing a committed write pointer. Rejected, truncated or malformed packets are rolled back by rewinding the FIFO write pointer to the packet's first word.
- Downstream readers consume only up to commit_wptr.

Parameters:
ADDR_WIDTH, 11, FIFO address width; pointers are ADDR_WIDTH+1 bits.
DATA_W, 18, payload bits per beat; FIFO word width is DATA_W+2.
MAX_PKT_LEN, 1518, maximum beats per packet; must be <= 2**ADDR_WIDTH-1, otherwise elaboration $error.
CNT_W, 16, statistics counter width.

Ports:
clk  in  1  clock.
reset  in  1  reset is synchronous and active-low.
in_valid  in  1  input beat valid.
in_ready  out  1  input beat accepted when in_valid && in_ready.
in_data  in  DATA_W  payload.
in_sop  in  1  first beat of packet.
in_eop  in  1  last beat of packet.
in_drop  in  1  filter verdict; sampled only on an accepted eop beat; 1 = discard packet.
fifo_wdata  out  DATA_W+2  {sop, eop, data}.
fifo_wen  out  1  FIFO write strobe.
fifo_full  in  1  FIFO full.
fifo_wptr  in  ADDR_WIDTH+1  FIFO current write pointer.
fifo_wrst  out  1  FIFO write-pointer reset strobe.
fifo_rst_wptr  out  ADDR_WIDTH+1  value loaded on fifo_wrst.
commit_wptr  out  ADDR_WIDTH+1  write pointer just past the last committed packet.
pkt_ok_cnt  out  CNT_W  committed packets; wraps.
pkt_drop_cnt  out  CNT_W  discarded packets (verdict, truncation, protocol error); wraps.
orphan_cnt  out  CNT_W  beats received outside a packet; wraps.

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE; commit_wptr=0; all counters 0; sop_wptr=0; pkt_len=0.
  - fifo_wen=0, fifo_wrst=0, fifo_rst_wptr=0.
  - Reset mid-packet abandons the packet without a rewind; the FIFO is reset by the same reset.
- Outputs:
  - fifo_wen, fifo_wdata and in_ready are combinational from state, inputs and fifo_full.
  - Zero-cycle latency: an accepted beat is written in the same cycle.
  - fifo_wrst and fifo_rst_wptr are registered state outputs.
- States:
  - IDLE:
    - in_ready = !fifo_full.
    - Accepted beat without sop: not written; orphan_cnt++.
    - Accepted sop beat, no eop: written; sop_wptr <= fifo_wptr; pkt_len <= 1; go to PKT.
    - Accepted sop+eop with drop=0: written; commit_wptr <= fifo_wptr+1; pkt_ok_cnt++; stay in IDLE.
    - Accepted sop+eop with drop=1: not written; pkt_drop_cnt++; stay in IDLE.
  - PKT:
    - in_ready = !fifo_full && !in_sop. A sop beat is held off and the state goes to REWIND (protocol error, pkt_drop_cnt++).
    - Accepted non-eop beat: written; pkt_len++.
    - If pkt_len reaches MAX_PKT_LEN without eop: pkt_drop_cnt++; go to DISCARD.
    - Accepted eop beat with drop=0: written; commit_wptr <= fifo_wptr+1; pkt_ok_cnt++; go to IDLE.
    - Accepted eop beat with drop=1: not written; pkt_drop_cnt++; go to REWIND.
  - DISCARD: in_ready=1; beats are accepted and never written; an accepted eop beat goes to REWIND.
  - REWIND:
    - Lasts exactly one cycle with in_ready=0; fifo_wrst=1; fifo_rst_wptr=sop_wptr.
    - Then go to IDLE. The FIFO's wptr equals sop_wptr the following cycle.
- Pointer arithmetic: modulo 2**(ADDR_WIDTH+1); wrap handled naturally.
- commit_wptr is never decremented, and rewinds never pass it (sop_wptr >= commit_wptr in FIFO order).
- fifo_full mid-packet: backpressure only, with no drop. Readers drain committed data; MAX_PKT_LEN < depth guarantees progress.
- Counters increment at most once per cycle.
- Never assert fifo_wen and fifo_wrst in the same cycle.

Test Plan:
- Reset, then 4-beat packet 0x1..0x4 with drop=0 -> 4 writes with words {1,0,1},{0,0,2},{0,0,3},{0,1,4}; commit_wptr 0->4; pkt_ok_cnt=1.
- Committed 4-beat packet, then 3-beat packet with drop=1 -> 2 writes, eop not written; fifo_wrst pulse with fifo_rst_wptr=4; commit_wptr stays 4; pkt_drop_cnt=1.
- MAX_PKT_LEN=8; 12-beat packet -> 8 writes; beats 9-12 accepted and not written; REWIND after eop to sop_wptr; pkt_drop_cnt=1.
- sop arriving in PKT after 2 beats -> in_ready=0 on that beat; REWIND to sop_wptr; next cycle the new sop is accepted and written at sop_wptr.
- 3 beats without sop in IDLE -> orphan_cnt=3, no writes. Single-beat sop+eop, drop=0 -> 1 write, commit_wptr+1.
- ADDR_WIDTH=4, fifo_full held 5 cycles mid-packet -> in_ready=0 for those 5 cycles, no writes, no drop. Pointer wrap 31->0 on commit -> commit_wptr=0.
